// File: rtl/ps2_pkg.sv
// Shared types and byte-0 field positions for the PS/2 mouse receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } frame_state_t;

  localparam int BTN_LSB       = 0;
  localparam int BTN_W         = 3;
  localparam int SYNC_BIT      = 3;
  localparam int XSIGN_BIT     = 4;
  localparam int YSIGN_BIT     = 5;
  localparam int XOVF_BIT      = 6;
  localparam int YOVF_BIT      = 7;
  localparam int MOUSE_DELTA_W = 9;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 line synchroniser, falling-edge detect, 11-bit frame FSM and inactivity timeout.
// Define PS2_PARITY_CHECK_EN to reject frames whose odd parity does not match.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 200_000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  input  logic       busy_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_error_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
  logic                   clk_prev_q;
  logic                   clk_s, data_s, fall;

  frame_state_t           state_q, state_d;
  logic [2:0]             bitcnt_q;
  logic [7:0]             shift_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   active, abort, parity_err;

  // Lines idle high, so the synchronisers come out of reset at 1 to avoid a fake edge
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data_i};
      clk_prev_q  <= clk_s;
    end
  end

  assign clk_s  = clk_sync_q[SYNC_STAGES-1];
  assign data_s = data_sync_q[SYNC_STAGES-1];
  assign fall   = clk_prev_q & ~clk_s;

  assign active = (state_q != IDLE) || busy_i;
  assign abort  = active && !fall && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else if (fall) begin
      case (state_q)
        IDLE:    if (!data_s) state_d = DATA;
        DATA:    if (bitcnt_q == 3'd7) state_d = PARITY;
        PARITY:  state_d = STOP;
        STOP:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (fall || abort || !active) cnt_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      bitcnt_q <= '0;
    end else if (fall) begin
      if (state_q == IDLE) bitcnt_q <= '0;
      else if (state_q == DATA) bitcnt_q <= bitcnt_q + 3'd1;
    end
  end

  // LSB arrives first, so shift in from the top
  always_ff @(posedge clk_i) begin
    if (fall && state_q == DATA) shift_q <= {data_s, shift_q[7:1]};
  end

`ifdef PS2_PARITY_CHECK_EN
  logic parity_q;

  always_ff @(posedge clk_i) begin
    if (fall && state_q == PARITY) parity_q <= data_s;
  end

  assign parity_err = ~^{shift_q, parity_q};
`else
  assign parity_err = 1'b0;
`endif

  always_comb begin
    byte_valid_o  = 1'b0;
    frame_error_o = abort;
    if (fall && state_q == STOP) begin
      byte_valid_o  = data_s && !parity_err;
      frame_error_o = !data_s || parity_err;
    end
  end

  assign byte_o = shift_q;

endmodule

// File: rtl/ps2_mouse_rx.sv
// PS/2 mouse receiver: deserialises frames and assembles 3-byte movement packets.
// Build option PS2_PARITY_CHECK_EN (see ps2_frame_rx) turns parity mismatches into frame errors.
module ps2_mouse_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 200_000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic                            ps2_clk_i,
  input  logic                            ps2_data_i,
  output logic                            packet_valid_o,
  output logic [BTN_W-1:0]                buttons_o,
  output logic signed [MOUSE_DELTA_W-1:0] dx_o,
  output logic signed [MOUSE_DELTA_W-1:0] dy_o,
  output logic [1:0]                      overflow_o,
  output logic                            frame_error_o
);

  logic [7:0] rx_byte;
  logic       rx_valid, rx_err;
  logic [1:0] idx_q, idx_d;
  logic [7:0] b0_q, b1_q;
  logic       load;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .SYNC_STAGES   (SYNC_STAGES)
  ) u_frame (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .ps2_clk_i    (ps2_clk_i),
    .ps2_data_i   (ps2_data_i),
    .busy_i       (idx_q != 2'd0),
    .byte_o       (rx_byte),
    .byte_valid_o (rx_valid),
    .frame_error_o(rx_err)
  );

  // Byte 0 must carry the always-one sync bit; otherwise drop it and stay aligned at 0
  always_comb begin
    idx_d = idx_q;
    load  = 1'b0;
    if (rx_err) begin
      idx_d = 2'd0;
    end else if (rx_valid) begin
      case (idx_q)
        2'd0:    if (rx_byte[SYNC_BIT]) idx_d = 2'd1;
        2'd1:    idx_d = 2'd2;
        2'd2: begin
          idx_d = 2'd0;
          load  = 1'b1;
        end
        default: idx_d = 2'd0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rx_valid && idx_q == 2'd0) b0_q <= rx_byte;
    if (rx_valid && idx_q == 2'd1) b1_q <= rx_byte;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      idx_q          <= 2'd0;
      packet_valid_o <= 1'b0;
      frame_error_o  <= 1'b0;
      buttons_o      <= '0;
      dx_o           <= '0;
      dy_o           <= '0;
      overflow_o     <= '0;
    end else begin
      idx_q          <= idx_d;
      packet_valid_o <= load;
      frame_error_o  <= rx_err;
      if (load) begin
        buttons_o  <= b0_q[BTN_LSB +: BTN_W];
        dx_o       <= {b0_q[XSIGN_BIT], b1_q};
        dy_o       <= {b0_q[YSIGN_BIT], rx_byte};
        overflow_o <= {b0_q[YOVF_BIT], b0_q[XOVF_BIT]};
      end
    end
  end

endmodule

// File: tb/tb_ps2_mouse_rx.sv
// Scoreboard bench for ps2_mouse_rx: stimulus pushes expected pulses, a monitor pops and compares.
module tb_ps2_mouse_rx;

  localparam int TO = 500;

  logic       clk = 1'b0;
  logic       reset_i, ps2_clk_i, ps2_data_i;
  logic       packet_valid_o, frame_error_o;
  logic [2:0] buttons_o;
  logic [8:0] dx_o, dy_o;
  logic [1:0] overflow_o;

  typedef struct {
    bit         is_err;
    logic [2:0] btn;
    logic [8:0] dx;
    logic [8:0] dy;
    logic [1:0] ovf;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  ps2_mouse_rx #(.TIMEOUT_CYCLES(TO), .SYNC_STAGES(2)) dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .ps2_clk_i     (ps2_clk_i),
    .ps2_data_i    (ps2_data_i),
    .packet_valid_o(packet_valid_o),
    .buttons_o     (buttons_o),
    .dx_o          (dx_o),
    .dy_o          (dy_o),
    .overflow_o    (overflow_o),
    .frame_error_o (frame_error_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every output pulse must match the oldest pending expectation
  always @(negedge clk) begin
    if (!reset_i && (packet_valid_o || frame_error_o)) begin
      if (packet_valid_o && frame_error_o) begin
        errors++;
        $display("FAIL pulse_overlap actual=both required=one");
      end
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse actual=pv%0b/fe%0b required=none", packet_valid_o, frame_error_o);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        chk("pulse_kind_err", {31'd0, frame_error_o}, {31'd0, e.is_err});
        if (!e.is_err && packet_valid_o) begin
          chk("buttons", {29'd0, buttons_o}, {29'd0, e.btn});
          chk("dx", {23'd0, dx_o}, {23'd0, e.dx});
          chk("dy", {23'd0, dy_o}, {23'd0, e.dy});
          chk("overflow", {30'd0, overflow_o}, {30'd0, e.ovf});
        end
      end
    end
  end

  task automatic push_pkt(input logic [2:0] b, input logic [8:0] x, input logic [8:0] y, input logic [1:0] o);
    ev_t e;
    e.is_err = 1'b0; e.btn = b; e.dx = x; e.dy = y; e.ovf = o;
    exp_q.push_back(e);
  endtask

  task automatic push_err();
    ev_t e;
    e.is_err = 1'b1; e.btn = '0; e.dx = '0; e.dy = '0; e.ovf = '0;
    exp_q.push_back(e);
  endtask

  task automatic ps2_bit(input logic b);
    @(negedge clk);
    ps2_data_i = b;
    repeat (10) @(negedge clk);
    ps2_clk_i = 1'b0;
    repeat (10) @(negedge clk);
    ps2_clk_i = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ bad_par);
    ps2_bit(~bad_stop);
    ps2_data_i = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic send_ok(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_i    = 1'b1;
    ps2_clk_i  = 1'b1;
    ps2_data_i = 1'b1;
    repeat (3) @(negedge clk);
    reset_i = 1'b0;
    @(negedge clk);
    chk("rst_pv", {31'd0, packet_valid_o}, 0);
    chk("rst_fe", {31'd0, frame_error_o}, 0);
    chk("rst_btn", {29'd0, buttons_o}, 0);
    chk("rst_dx", {23'd0, dx_o}, 0);
    chk("rst_dy", {23'd0, dy_o}, 0);
    chk("rst_ovf", {30'd0, overflow_o}, 0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i    = 1'b1;
    ps2_clk_i  = 1'b1;
    ps2_data_i = 1'b1;

    // Reset and quiet idle
    do_reset();
    repeat (1000) @(negedge clk);

    // Basic packet
    push_pkt(3'b001, 9'h005, 9'h1FB, 2'b00);
    send_ok(8'h29); send_ok(8'h05); send_ok(8'hFB);
    wait_drain("pkt_basic", 200);

    // Wrong parity on byte 1
`ifdef PS2_PARITY_CHECK_EN
    push_err();
    send_ok(8'h08); send_frame(8'h05, 1'b1, 1'b0);
    wait_drain("parity_err", 200);
    push_pkt(3'b000, 9'h001, 9'h002, 2'b00);
    send_ok(8'h08); send_ok(8'h01); send_ok(8'h02);
`else
    push_pkt(3'b000, 9'h001, 9'h002, 2'b00);
    send_ok(8'h08); send_frame(8'h01, 1'b1, 1'b0); send_ok(8'h02);
`endif
    wait_drain("pkt_after_parity", 200);

    // Bad stop bit aborts the packet in progress
    push_err();
    send_ok(8'h08); send_frame(8'h01, 1'b0, 1'b1);
    wait_drain("stop_err", 200);

    // Resync: byte without sync bit dropped
    push_pkt(3'b010, 9'h180, 9'h001, 2'b00);
    send_ok(8'h00); send_ok(8'h1A); send_ok(8'h80); send_ok(8'h01);
    wait_drain("pkt_resync", 200);

    // Timeout after two bytes, then overflow packet
    push_err();
    send_ok(8'h08); send_ok(8'h03);
    wait_drain("timeout_err", 3 * TO);
    push_pkt(3'b001, 9'h0FF, 9'h000, 2'b11);
    send_ok(8'hC9); send_ok(8'hFF); send_ok(8'h00);
    wait_drain("pkt_overflow", 200);

    // Reset during byte-2 data bits
    send_ok(8'h08); send_ok(8'h01);
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1);
    do_reset();
    repeat (50) @(negedge clk);
    push_pkt(3'b000, 9'h110, 9'h1F0, 2'b00);
    send_ok(8'h38); send_ok(8'h10); send_ok(8'hF0);
    wait_drain("pkt_after_reset", 200);
    chk("hold_dx", {23'd0, dx_o}, 32'h110);

    repeat (20) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
